multi_channel_note_gen: RTL and testbench

MULTI_CHANNEL_NOTE_GEN -- requirements
Module: multi_channel_note_gen

---
 rtl/multi_channel_note_gen.sv | 121 ++++++++++++
 tb/tb_multi_channel_note_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_note_gen.sv
// Multi-channel square-wave tone generator with a saturating signed mixer.
// Every channel runs its own half-period counter. Divider and octave changes
// are shadowed and only take effect at the channel's wrap boundary, so a
// note change never produces a shortened pulse.
module multi_channel_note_gen #(
  parameter int CH       = 4,
  parameter int DIV_W    = 22,
  parameter int AW       = 16,
  parameter int AMP_STEP = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [CH-1:0]          ch_en,
  input  logic [CH*DIV_W-1:0]    note_div,
  input  logic [1:0]             octave,
  input  logic [2:0]             volume,
  output logic signed [AW-1:0]   audio_out,
  output logic [CH-1:0]          phase,
  output logic                   clip
);

  // Four bits of headroom are enough for 8 channels at full volume.
  localparam int SW = AW + 4;
  localparam logic signed [SW-1:0] MAX_V = SW'((64'sd1 <<< (AW - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] MIN_V = SW'(-(64'sd1 <<< (AW - 1)));

  logic [DIV_W-1:0]     sdiv [CH];
  logic [DIV_W-1:0]     cnt  [CH];
  logic [1:0]           soct [CH];
  logic [DIV_W-1:0]     eff  [CH];
  logic [CH-1:0]        active;

  logic signed [SW-1:0] amp;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sat;
  logic                 over;

  // Effective half-period from the shadow divider and latched octave.
  // Octave 0 doubles the divider and pins at all-ones instead of wrapping.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      eff[k] = sdiv[k];
      case (soct[k])
        2'd0: begin
          if (sdiv[k][DIV_W-1]) eff[k] = '1;
          else                  eff[k] = {sdiv[k][DIV_W-2:0], 1'b0};
        end
        2'd1: eff[k] = sdiv[k];
        2'd2: eff[k] = sdiv[k] >> 1;
        default: eff[k] = sdiv[k] >> 2;
      endcase
      active[k] = ch_en[k] && (eff[k] >= DIV_W'(2));
    end
  end

  // Per-channel counters, phases and shadow registers; everything freezes
  // while en is low so playback resumes mid-period without a phase reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        cnt[k]  <= '0;
        sdiv[k] <= '0;
        soct[k] <= 2'd0;
      end
      phase <= '0;
    end else if (en) begin
      for (int k = 0; k < CH; k++) begin
        if (!active[k]) begin
          cnt[k]   <= '0;
          phase[k] <= 1'b0;
          sdiv[k]  <= note_div[k*DIV_W +: DIV_W];
          soct[k]  <= octave;
        end else if (cnt[k] >= eff[k] - DIV_W'(1)) begin
          cnt[k]   <= '0;
          phase[k] <= ~phase[k];
          sdiv[k]  <= note_div[k*DIV_W +: DIV_W];
          soct[k]  <= octave;
        end else begin
          cnt[k] <= cnt[k] + DIV_W'(1);
        end
      end
    end
  end

  // Signed mix of active channels followed by saturation to the output range.
  always_comb begin
    amp = $signed(SW'(volume) * SW'(AMP_STEP));
    sum = '0;
    for (int k = 0; k < CH; k++) begin
      if (active[k]) begin
        if (phase[k]) sum = sum + amp;
        else          sum = sum - amp;
      end
    end
    over = 1'b0;
    sat  = sum;
    if (sum > MAX_V) begin
      sat  = MAX_V;
      over = 1'b1;
    end else if (sum < MIN_V) begin
      sat  = MIN_V;
      over = 1'b1;
    end
  end

  // Output register; pausing forces silence on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      audio_out <= '0;
      clip      <= 1'b0;
    end else if (en) begin
      audio_out <= sat[AW-1:0];
      clip      <= over;
    end else begin
      audio_out <= '0;
      clip      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_channel_note_gen.sv
// Bench for multi_channel_note_gen: a 4-channel and an 8-channel instance
// share global controls and are compared every cycle against a behavioural
// model of half-period tone generation and saturating mixing.
module tb_multi_channel_note_gen;

  localparam int DW = 22;
  localparam int AMAX = 32767;
  localparam int AMIN = -32768;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [1:0]      octave;
  logic [2:0]      volume;
  logic [3:0]      ch_en4;
  logic [7:0]      ch_en8;
  logic [4*DW-1:0] note_div4;
  logic [8*DW-1:0] note_div8;
  logic signed [15:0] audio4, audio8;
  logic [3:0]      phase4;
  logic [7:0]      phase8;
  logic            clip4, clip8;

  int div4 [4];
  int div8 [8];

  int n_chk  = 0;
  int n_pass = 0;

  // model state, index 0 = 4-channel instance, 1 = 8-channel instance
  int m_pos [2][8];
  int m_div [2][8];
  int m_oct [2][8];
  int m_ph  [2][8];
  int m_audio [2];
  int m_clip  [2];

  always #5 clk = ~clk;

  always_comb begin
    note_div4 = '0;
    note_div8 = '0;
    for (int k = 0; k < 4; k++) note_div4[k*DW +: DW] = div4[k][DW-1:0];
    for (int k = 0; k < 8; k++) note_div8[k*DW +: DW] = div8[k][DW-1:0];
  end

  multi_channel_note_gen #(.CH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en4), .note_div(note_div4),
    .octave(octave), .volume(volume), .audio_out(audio4), .phase(phase4), .clip(clip4)
  );

  multi_channel_note_gen #(.CH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en8), .note_div(note_div8),
    .octave(octave), .volume(volume), .audio_out(audio8), .phase(phase8), .clip(clip8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Half-period length in clock cycles for a divider at a given octave.
  function automatic int half_len(input int dv, input int oc);
    int len;
    case (oc)
      0: begin
        len = dv * 2;
        if (len > (1 << DW) - 1) len = (1 << DW) - 1;
      end
      1: len = dv;
      2: len = dv / 2;
      default: len = dv / 4;
    endcase
    return len;
  endfunction

  task automatic model_step(input int d, input int n, input logic [7:0] che);
    int  sum;
    int  len;
    int  amp;
    bit  on;
    sum = 0;
    amp = int'(volume) * 1024;
    for (int k = 0; k < n; k++) begin
      on = che[k] && (half_len(m_div[d][k], m_oct[d][k]) >= 2);
      if (on) sum += (m_ph[d][k] != 0) ? amp : -amp;
    end
    if (en) begin
      m_audio[d] = (sum > AMAX) ? AMAX : (sum < AMIN) ? AMIN : sum;
      m_clip[d]  = (sum > AMAX || sum < AMIN) ? 1 : 0;
      for (int k = 0; k < n; k++) begin
        len = half_len(m_div[d][k], m_oct[d][k]);
        if (!(che[k] && len >= 2)) begin
          m_pos[d][k] = 0;
          m_ph[d][k]  = 0;
          m_div[d][k] = (d == 0) ? div4[k] : div8[k];
          m_oct[d][k] = int'(octave);
        end else if (m_pos[d][k] + 1 >= len) begin
          m_pos[d][k] = 0;
          m_ph[d][k]  = 1 - m_ph[d][k];
          m_div[d][k] = (d == 0) ? div4[k] : div8[k];
          m_oct[d][k] = int'(octave);
        end else begin
          m_pos[d][k]++;
        end
      end
    end else begin
      m_audio[d] = 0;
      m_clip[d]  = 0;
    end
  endtask

  // Reference model advances on the same edges as the DUTs.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 8; k++) begin
          m_pos[d][k] = 0; m_div[d][k] = 0; m_oct[d][k] = 0; m_ph[d][k] = 0;
        end
        m_audio[d] = 0;
        m_clip[d]  = 0;
      end
    end else begin
      model_step(0, 4, {4'b0, ch_en4});
      model_step(1, 8, ch_en8);
    end
  end

  function automatic int model_phase(input int d, input int n);
    int v;
    v = 0;
    for (int k = 0; k < n; k++) if (m_ph[d][k] != 0) v |= (1 << k);
    return v;
  endfunction

  task automatic cycle_check();
    @(negedge clk);
    chk("audio4", int'(audio4), m_audio[0]);
    chk("phase4", int'(phase4), model_phase(0, 4));
    chk("clip4",  int'(clip4),  m_clip[0]);
    chk("audio8", int'(audio8), m_audio[1]);
    chk("phase8", int'(phase8), model_phase(1, 8));
    chk("clip8",  int'(clip8),  m_clip[1]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_check();
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_audio4"}, int'(audio4), 0);
    chk({tag, "_phase4"}, int'(phase4), 0);
    chk({tag, "_clip8"},  int'(clip8),  0);
    chk({tag, "_audio8"}, int'(audio8), 0);
    chk({tag, "_phase8"}, int'(phase8), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; octave = 2'd1; volume = 3'd0;
    ch_en4 = '0; ch_en8 = '0;
    for (int k = 0; k < 4; k++) div4[k] = 0;
    for (int k = 0; k < 8; k++) div8[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_audio4", int'(audio4), 0);
    chk("rst_phase8", int'(phase8), 0);
    chk("rst_clip8",  int'(clip8),  0);

    // Single tone, divider 100, volume 7.
    ch_en4 = 4'b0001; div4[0] = 100; volume = 3'd7; en = 1'b1;
    rst = 1'b1;
    run(100);
    chk("tone_phase_pre", int'(phase4[0]), 0);
    chk("tone_audio_pre", int'(audio4), -7168);
    run(1);
    chk("tone_phase_toggle", int'(phase4[0]), 1);
    run(1);
    chk("tone_audio_pos", int'(audio4), 7168);
    run(30);
    // Octave up mid-period, then a 37-cycle pause mid-period.
    octave = 2'd2;
    run(200);
    en = 1'b0;
    run(1);
    chk("pause_audio", int'(audio4), 0);
    run(36);
    en = 1'b1;
    run(120);

    // Silent-channel cases: divider 1, and divider 5 at octave 3.
    ch_en4 = 4'b0011; div4[1] = 1;
    run(20);
    chk("silent_div1", int'(phase4[1]), 0);
    octave = 2'd3; div4[1] = 5;
    run(20);
    chk("silent_oct3", int'(phase4[1]), 0);

    // All channels in phase at divider 10: clip only on the 8-channel mix.
    async_reset_check("rst_mid");
    octave = 2'd1; volume = 3'd7;
    ch_en4 = 4'hF; ch_en8 = 8'hFF;
    for (int k = 0; k < 4; k++) div4[k] = 10;
    for (int k = 0; k < 8; k++) div8[k] = 10;
    async_reset_check("rst_sync");
    run(5);
    chk("inphase_audio4", int'(audio4), -28672);
    chk("inphase_clip4",  int'(clip4), 0);
    chk("inphase_audio8", int'(audio8), AMIN);
    chk("inphase_clip8",  int'(clip8), 1);
    run(60);

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle_check();
      if ($urandom_range(0, 19) == 0) octave = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) volume = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) ch_en4[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 39) == 0) ch_en8[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) div4[$urandom_range(0, 3)] = $urandom_range(0, 30);
      if ($urandom_range(0, 9) == 0) div8[$urandom_range(0, 7)] = $urandom_range(0, 30);
      if ($urandom_range(0, 999) == 0) async_reset_check("rst_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
